sp_ram_initiator: RTL and testbench

Initiator for the synchronous single-port N x 32 bit byte-enable RAM. It turns an in-order valid/ready request stream into RAM port cycles and returns read data through a credit-protected response FIFO. It tracks the RAM's fixed read latency, which is 1 cycle, or 2 with RAM output registers. It sits between a DMA/bus adapter and one RAM instance and owns every RAM port signal.

---
 rtl/sp_ram_initiator_pkg.sv | 21 ++
 rtl/sp_ram_resp_fifo.sv | 64 ++++++
 rtl/sp_ram_initiator.sv | 132 +++++++++++++
 tb/tb_sp_ram_initiator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_initiator_pkg.sv
// Shared types and helpers for the single-port RAM initiator and its response FIFO.
package sp_ram_initiator_pkg;

    localparam int unsigned DATA_BYTES = 4;
    localparam int unsigned DATA_W     = 8 * DATA_BYTES;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              wr;
    } resp_t;

    typedef struct packed {
        logic vld;
        logic wr;
    } stage_t;

    function automatic int unsigned lat(input int unsigned out_regs);
        return 1 + out_regs;
    endfunction

endpackage

// File: rtl/sp_ram_resp_fifo.sv
// Response FIFO of resp_t entries; any depth >= 2, same-cycle push and pop allowed.
module sp_ram_resp_fifo
    import sp_ram_initiator_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  resp_t data_i,
    input  logic  pop_i,
    output resp_t data_o,
    output logic  empty_o,
    output logic  full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    resp_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !full_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// Drives a single-port byte-enable RAM from a request stream and returns credit-protected
// responses. Define SP_RAM_INITIATOR_WRESP_EN to give writes a response as well.
module sp_ram_initiator
    import sp_ram_initiator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned OUT_REGS   = 0,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Req_SI,
    output logic                  ReqRdy_SO,
    input  logic                  ReqWr_SI,
    input  logic [DATA_BYTES-1:0] ReqBEn_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [DATA_W-1:0]     ReqData_DI,
    output logic                  Resp_SO,
    input  logic                  RespRdy_SI,
    output logic [DATA_W-1:0]     RespData_DO,
    output logic                  RespWr_SO,
    output logic                  CSel_SO,
    output logic                  WrEn_SO,
    output logic [DATA_BYTES-1:0] BEn_SO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    output logic [DATA_W-1:0]     WrData_DO,
    input  logic [DATA_W-1:0]     RdData_DI,
    output logic                  Idle_SO
);

    localparam int unsigned LAT   = lat(OUT_REGS);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    if (RESP_DEPTH < 2) begin : g_depth_chk
        $error("RESP_DEPTH must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    stage_t           pipe_q [LAT];
    stage_t           pipe_d [LAT];
    stage_t           stage_in;
    logic             accept;
    logic             resp_req;
    logic             pop;
    logic             pipe_busy;
    logic             push;
    resp_t            push_data;
    resp_t            fifo_head;
    logic             fifo_empty;
    logic             fifo_full;

    assign ReqRdy_SO = (cnt_q < CNT_W'(RESP_DEPTH)) && !Rst_RI;
    assign accept    = Req_SI && ReqRdy_SO;

    assign CSel_SO   = accept;
    assign WrEn_SO   = accept && ReqWr_SI;
    assign BEn_SO    = ReqWr_SI ? ReqBEn_SI : '0;
    assign Addr_DO   = ReqAddr_DI;
    assign WrData_DO = ReqData_DI;

`ifdef SP_RAM_INITIATOR_WRESP_EN
    assign resp_req = accept;
    assign stage_in = '{vld: accept, wr: ReqWr_SI};
`else
    // Writes are fire-and-forget: they never occupy the pipe or consume a credit.
    assign resp_req = accept && !ReqWr_SI;
    assign stage_in = '{vld: resp_req, wr: 1'b0};
`endif

    assign pop       = Resp_SO && RespRdy_SI;
    assign push      = pipe_q[LAT-1].vld;
    assign push_data = '{data: pipe_q[LAT-1].wr ? '0 : RdData_DI, wr: pipe_q[LAT-1].wr};

    // Latency pipe shift and credit counter update.
    always_comb begin
        pipe_d[0] = stage_in;
        for (int i = 1; i < int'(LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        cnt_d = cnt_q;
        case ({resp_req, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        pipe_busy = 1'b0;
        for (int i = 0; i < int'(LAT); i++) begin
            pipe_busy = pipe_busy | pipe_q[i].vld;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < int'(LAT); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    sp_ram_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i   (Clk_CI),
        .rst_i   (Rst_RI),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign Resp_SO     = !fifo_empty;
    assign RespData_DO = fifo_empty ? '0 : fifo_head.data;
    assign RespWr_SO   = !fifo_empty && fifo_head.wr;
    assign Idle_SO     = (cnt_q == '0) && !pipe_busy;

    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        !(push && fifo_full))
        else $error("push into full response FIFO");

    a_resp_stable: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        (Resp_SO && !RespRdy_SI) |=> (Resp_SO && $stable(RespData_DO) && $stable(RespWr_SO)))
        else $error("response payload changed under backpressure");

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Scoreboard bench for sp_ram_initiator with a behavioural byte-enable RAM (OUT_REGS=1).
module tb_sp_ram_initiator;

    localparam int unsigned OUT_REGS   = 1;
    localparam int unsigned RESP_DEPTH = 4;
    localparam int unsigned LAT        = 1 + OUT_REGS;
`ifdef SP_RAM_INITIATOR_WRESP_EN
    localparam bit WRESP = 1'b1;
`else
    localparam bit WRESP = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_rdy, req_wr;
    logic [3:0]  req_ben;
    logic [9:0]  req_addr;
    logic [31:0] req_data;
    logic        resp, resp_rdy, resp_wr;
    logic [31:0] resp_data;
    logic        csel, wren;
    logic [3:0]  ben;
    logic [9:0]  addr;
    logic [31:0] wdata, rdata;
    logic        idle;

    int          total = 0;
    int          bad   = 0;
    int          n_resp = 0;
    int          cyc = 0;
    logic [31:0] last_rd = '0;
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] ref_mem [1024];

    logic [31:0] ram [1024];
    logic [31:0] rd1, rd2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sp_ram_initiator #(
        .ADDR_WIDTH (10),
        .OUT_REGS   (OUT_REGS),
        .RESP_DEPTH (RESP_DEPTH)
    ) u_dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .Req_SI      (req),
        .ReqRdy_SO   (req_rdy),
        .ReqWr_SI    (req_wr),
        .ReqBEn_SI   (req_ben),
        .ReqAddr_DI  (req_addr),
        .ReqData_DI  (req_data),
        .Resp_SO     (resp),
        .RespRdy_SI  (resp_rdy),
        .RespData_DO (resp_data),
        .RespWr_SO   (resp_wr),
        .CSel_SO     (csel),
        .WrEn_SO     (wren),
        .BEn_SO      (ben),
        .Addr_DO     (addr),
        .WrData_DO   (wdata),
        .RdData_DI   (rdata),
        .Idle_SO     (idle)
    );

    // Behavioural RAM with optional output register.
    always @(posedge clk) begin
        if (csel) begin
            if (wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (ben[b]) ram[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rd1 <= ram[addr];
            end
        end
        rd2 <= rd1;
    end
    assign rdata = (OUT_REGS != 0) ? rd2 : rd1;

    // Scoreboard: expectations pushed on accept, compared on pop.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (resp && resp_rdy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: got data=%h wr=%b, required no response", resp_data, resp_wr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (resp_data !== mon_e.data || resp_wr !== mon_e.wr) begin
                        bad++;
                        $display("FAIL resp_payload: got data=%h wr=%b, required data=%h wr=%b",
                                 resp_data, resp_wr, mon_e.data, mon_e.wr);
                    end
                end
                n_resp++;
                if (!resp_wr) last_rd = resp_data;
            end
            if (req && req_rdy) begin
                if (req_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_ben[b]) ref_mem[req_addr][8*b +: 8] = req_data[8*b +: 8];
                    end
`ifdef SP_RAM_INITIATOR_WRESP_EN
                    exp_q.push_back('{data: 32'h0, wr: 1'b1});
`endif
                end else begin
                    exp_q.push_back('{data: ref_mem[req_addr], wr: 1'b0});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [3:0] be,
                         input logic [9:0] a, input logic [31:0] d);
        req = v; req_wr = w; req_ben = be; req_addr = a; req_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; resp_rdy = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_rdy !== 1'b0) begin bad++; $display("FAIL rdy_in_reset: got %b, required 0", req_rdy); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL rdy_after_reset: got %b, required 1", req_rdy); end
        total++; if (resp !== 1'b0) begin bad++; $display("FAIL resp_after_reset: got %b, required 0", resp); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rdata_after_reset: got %h, required 0", resp_data); end
        total++; if (resp_wr !== 1'b0) begin bad++; $display("FAIL rwr_after_reset: got %b, required 0", resp_wr); end
        total++; if (csel !== 1'b0 || wren !== 1'b0 || ben !== 4'h0) begin
            bad++; $display("FAIL ram_after_reset: got csel=%b wren=%b ben=%h, required 0 0 0", csel, wren, ben); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL idle_after_reset: got %b, required 1", idle); end
    endtask

    task automatic test_write_read();
        int n0, c_r, first;
        n0 = n_resp; first = -1;
        @(posedge clk); #1 drive(1'b1, 1'b1, 4'hF, 10'd5, 32'hCAFEF00D);
        @(negedge clk);
        total++; if (csel !== 1'b1 || wren !== 1'b1 || ben !== 4'hF || addr !== 10'd5 || wdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL wr_port: got csel=%b wren=%b ben=%h addr=%0d wdata=%h, required 1 1 f 5 cafef00d",
                            csel, wren, ben, addr, wdata); end
        @(posedge clk); #1 drive(1'b1, 1'b0, 4'hF, 10'd5, 32'h0);
        @(negedge clk);
        c_r = cyc;
        total++; if (csel !== 1'b1 || wren !== 1'b0 || ben !== 4'h0) begin
            bad++; $display("FAIL rd_port: got csel=%b wren=%b ben=%h, required 1 0 0", csel, wren, ben); end
        @(posedge clk); #1 drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp && !resp_wr) begin first = cyc; break; end
        end
        total++; if (first - c_r != int'(LAT) + 1) begin
            bad++; $display("FAIL rd_latency: got %0d cycles, required %0d", first - c_r, LAT + 1); end
        for (int i = 0; i < 64; i++) begin @(negedge clk); if (idle && exp_q.size() == 0) break; end
        total++; if (n_resp - n0 != (WRESP ? 2 : 1)) begin
            bad++; $display("FAIL wr_rd_count: got %0d, required %0d", n_resp - n0, WRESP ? 2 : 1); end
        total++; if (last_rd !== 32'hCAFEF00D) begin bad++; $display("FAIL wr_rd_data: got %h, required cafef00d", last_rd); end
    endtask

    task automatic test_byte_enables();
        @(posedge clk); #1 drive(1'b1, 1'b1, 4'hF, 10'd9, 32'hFFFFFFFF);
        @(posedge clk); #1 drive(1'b1, 1'b1, 4'b0101, 10'd9, 32'h00000000);
        @(posedge clk); #1 drive(1'b1, 1'b0, 4'h0, 10'd9, 32'h0);
        @(posedge clk); #1 drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        for (int i = 0; i < 64; i++) begin @(negedge clk); if (idle && exp_q.size() == 0) break; end
        total++; if (last_rd !== 32'hFF00FF00) begin bad++; $display("FAIL byte_en: got %h, required ff00ff00", last_rd); end
    endtask

    task automatic test_back_to_back();
        int          drops;
        logic [31:0] mask, exp_mask;
        drops = 0; mask = '0; exp_mask = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1 drive(1'b1, 1'b1, 4'hF, 10'(i), 32'(i) * 32'h11111111);
        end
        @(posedge clk); #1 drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        for (int i = 0; i < 64; i++) begin @(negedge clk); if (idle && exp_q.size() == 0) break; end
        for (int k = 0; k < 16 + int'(LAT) + 4; k++) begin
            @(posedge clk); #1;
            if (k < 16) drive(1'b1, 1'b0, 4'h0, 10'(k), 32'h0);
            else        drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
            @(negedge clk);
            if (k < 16 && req_rdy !== 1'b1) drops++;
            mask[k] = resp;
            exp_mask[k] = (k >= int'(LAT) + 1) && (k <= int'(LAT) + 16);
        end
        total++; if (drops != 0) begin bad++; $display("FAIL b2b_ready: got %0d stalls, required 0", drops); end
        total++; if (mask !== exp_mask) begin bad++; $display("FAIL b2b_resp_timing: got %h, required %h", mask, exp_mask); end
    endtask

    task automatic test_backpressure();
        int n_acc, n_extra, unstable;
        n_acc = 0; n_extra = 0; unstable = 0;
        resp_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1 drive(1'b1, 1'b0, 4'h0, 10'(k % 16), 32'h0);
            @(negedge clk);
            if (req_rdy) n_acc++;
        end
        total++; if (n_acc != int'(RESP_DEPTH)) begin bad++; $display("FAIL bp_accepts: got %0d, required %0d", n_acc, RESP_DEPTH); end
        total++; if (req_rdy !== 1'b0 || resp !== 1'b1) begin
            bad++; $display("FAIL bp_state: got rdy=%b resp=%b, required rdy=0 resp=1", req_rdy, resp); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (exp_q.size() == 0 || resp !== 1'b1 || resp_data !== exp_q[0].data || resp_wr !== 1'b0) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", unstable); end
        @(posedge clk); #1 resp_rdy = 1'b1;
        @(negedge clk);
        if (req_rdy) n_extra++;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 resp_rdy = 1'b0;
            @(negedge clk);
            if (req_rdy) n_extra++;
        end
        total++; if (n_extra != 1) begin bad++; $display("FAIL bp_extra_accept: got %0d, required 1", n_extra); end
        @(posedge clk); #1 drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0); resp_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin @(negedge clk); if (idle && exp_q.size() == 0) break; end
        total++; if (idle !== 1'b1 || exp_q.size() != 0) begin
            bad++; $display("FAIL bp_drain: got idle=%b pending=%0d, required idle=1 pending=0", idle, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n_acc, n_seen;
        n_acc = 0; n_seen = 0;
        resp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 drive(1'b1, 1'b0, 4'h0, 10'(k), 32'h0);
            @(negedge clk);
            if (req_rdy) n_acc++;
        end
        total++; if (n_acc != 3) begin bad++; $display("FAIL rm_accepts: got %0d, required 3", n_acc); end
        @(posedge clk); #1 drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0); rst = 1'b1;
        @(negedge clk);
        total++; if (req_rdy !== 1'b0) begin bad++; $display("FAIL rm_rdy_in_reset: got %b, required 0", req_rdy); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (resp !== 1'b0 || resp_data !== 32'h0 || idle !== 1'b1 || req_rdy !== 1'b1 || csel !== 1'b0) begin
            bad++; $display("FAIL rm_reset_values: got resp=%b data=%h idle=%b rdy=%b csel=%b, required 0 0 1 1 0",
                            resp, resp_data, idle, req_rdy, csel); end
        resp_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp) n_seen++;
        end
        total++; if (n_seen != 0 || idle !== 1'b1) begin
            bad++; $display("FAIL rm_no_resp: got %0d response cycles idle=%b, required 0 and idle=1", n_seen, idle); end
    endtask

    task automatic test_wresp();
        int n0, n_acc;
        n0 = n_resp; n_acc = 0;
        resp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            case (k)
                0:       drive(1'b1, 1'b1, 4'hF, 10'd30, 32'h12345678);
                1:       drive(1'b1, 1'b0, 4'h0, 10'd30, 32'h0);
                2:       drive(1'b1, 1'b1, 4'hF, 10'd31, 32'h0BADBEEF);
                default: drive(1'b1, 1'b0, 4'h0, 10'd31, 32'h0);
            endcase
            @(negedge clk);
            if (req_rdy) n_acc++;
        end
        total++; if (n_acc != 4) begin bad++; $display("FAIL wresp_accepts: got %0d, required 4", n_acc); end
        @(posedge clk); #1 drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        total++; if (req_rdy !== !WRESP) begin bad++; $display("FAIL wresp_credit: got rdy=%b, required %b", req_rdy, !WRESP); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL wresp_busy: got idle=%b, required 0", idle); end
        resp_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin @(negedge clk); if (idle && exp_q.size() == 0) break; end
        total++; if (n_resp - n0 != (WRESP ? 4 : 2)) begin
            bad++; $display("FAIL wresp_count: got %0d, required %0d", n_resp - n0, WRESP ? 4 : 2); end
    endtask

    initial begin
        rst = 1'b1; resp_rdy = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wresp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
